// File: rtl/servo_job_sequencer.sv
// servo_job_sequencer: turns decoded UART command bytes into servo jobs.
// A job moves the servo to a storage angle, holds it for a dwell set by the last
// position byte, then returns home. This block is the only writer of the PWM
// generator's pulse width and load strobe.
// Optional feature macro: SERVO_SEQ_QUEUE_EN (one-deep pending job slot).
module servo_job_sequencer #(
    parameter int unsigned PW_MIN        = 50000,
    parameter int unsigned PW_STEP       = 6000,
    parameter int unsigned PW_HOME       = 110000,
    parameter int unsigned DWELL_UNIT    = 10,
    parameter int unsigned RETURN_FRAMES = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_start,
    output logic [25:0] pulse_width,
    output logic        pw_load,
    output logic        busy,
    output logic        done,
    output logic        drop
);

    typedef enum logic [1:0] {StIdle, StGo, StHold, StRet} state_e;

    state_e      state_q, state_d;
    logic [4:0]  position_q, position_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] ret_q, ret_d;
    logic [25:0] pw_q, pw_d;
    logic        load_q, load_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;
    logic        drop_late_q, drop_late_d;

    logic        pos_hit, req, start_new, busy_req, ret_exit, reject;
    logic [3:0]  req_idx;
    logic        launch;
    logic [3:0]  launch_idx;
    logic        pend_full;
    logic [3:0]  pend_idx;

    assign pos_hit   = rx_valid && (rx_data >= 8'd1) && (rx_data <= 8'd16);
    assign req       = rx_valid && (rx_data >= 8'd103) && (rx_data <= 8'd113);
    assign req_idx   = 4'(rx_data - 8'd103);
    // A request starts directly only from an idle block with nothing queued.
    assign start_new = req && (state_q == StIdle) && !pend_full;
    assign busy_req  = req && !start_new;
    assign ret_exit  = (state_q == StRet) && frame_start && (ret_q <= 16'd1);

`ifdef SERVO_SEQ_QUEUE_EN
    logic       pend_q, pend_d;
    logic [3:0] pend_idx_q, pend_idx_d;
    logic       pend_take;

    // The queued job launches from idle, or in the same cycle the current job ends.
    assign pend_take = pend_q && ((state_q == StIdle) || ret_exit);
    assign pend_full = pend_q;
    assign pend_idx  = pend_idx_q;
    assign reject    = busy_req && pend_q;

    // Pending slot: freed on launch, refilled by a busy request only if it was empty.
    always_comb begin
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        if (pend_take) begin
            pend_d = 1'b0;
        end
        if (busy_req && !pend_q) begin
            pend_d     = 1'b1;
            pend_idx_d = req_idx;
        end
    end

    // Pending slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_idx_q <= 4'd0;
        end else begin
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end
`else
    assign pend_full = 1'b0;
    assign pend_idx  = 4'd0;
    assign reject    = busy_req;
`endif

    // Next-state and registered-output logic for the job FSM.
    always_comb begin
        state_d     = state_q;
        position_d  = position_q;
        dwell_d     = dwell_q;
        ret_d       = ret_q;
        pw_d        = pw_q;
        load_d      = 1'b0;
        done_d      = 1'b0;
        launch      = 1'b0;
        launch_idx  = req_idx;
        if (pos_hit) begin
            position_d = rx_data[4:0];
        end
        unique case (state_q)
            StIdle: begin
                if (pend_full) begin
                    launch     = 1'b1;
                    launch_idx = pend_idx;
                end else if (req) begin
                    launch = 1'b1;
                end
            end
            // The frame_start seen alongside the entry load is not counted.
            StGo: begin
                if (frame_start && !load_q) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (frame_start) begin
                    if (dwell_q <= 16'd1) begin
                        dwell_d = 16'd0;
                        state_d = StRet;
                        pw_d    = 26'(PW_HOME);
                        load_d  = 1'b1;
                        ret_d   = 16'(RETURN_FRAMES);
                    end else begin
                        dwell_d = dwell_q - 16'd1;
                    end
                end
            end
            StRet: begin
                if (ret_exit) begin
                    ret_d   = 16'd0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (pend_full) begin
                        launch     = 1'b1;
                        launch_idx = pend_idx;
                    end
                end else if (frame_start) begin
                    ret_d = ret_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (launch) begin
            state_d = StGo;
            pw_d    = 26'(PW_MIN) + 26'(launch_idx) * 26'(PW_STEP);
            load_d  = 1'b1;
            dwell_d = 16'(position_q) * 16'(DWELL_UNIT);
        end
    end

    // A reject landing on the done cycle is pushed one cycle later so the pulses never overlap.
    always_comb begin
        drop_d      = (reject && !done_d) || drop_late_q;
        drop_late_d = reject && done_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            position_q  <= 5'd1;
            dwell_q     <= 16'd0;
            ret_q       <= 16'd0;
            pw_q        <= 26'(PW_HOME);
            load_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            drop_late_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            dwell_q     <= dwell_d;
            ret_q       <= ret_d;
            pw_q        <= pw_d;
            load_q      <= load_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            drop_late_q <= drop_late_d;
        end
    end

    assign pulse_width = pw_q;
    assign pw_load     = load_q;
    assign done        = done_q;
    assign drop        = drop_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_servo_job_sequencer.sv
// Directed bench for servo_job_sequencer; expectations follow SERVO_SEQ_QUEUE_EN.
module tb_servo_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [25:0] pulse_width;
    logic        pw_load, busy, done, drop;

    int tests = 0;
    int fails = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    int l0, d0, p0;
    logic [25:0] last_load_pw = '0;
    logic [25:0] prev_pw = '0;
    logic        prev_load = 1'b0;
    logic        prev_rst = 1'b0;

    servo_job_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .pulse_width (pulse_width),
        .pw_load     (pw_load),
        .busy        (busy),
        .done        (done),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (3) tick();
        end
    endtask

    // Pulse counters and cycle-level invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (pw_load) begin
            load_cnt++;
            last_load_pw = pulse_width;
        end
        if (done) done_cnt++;
        if (drop) drop_cnt++;
        chk("load_twice", pw_load & prev_load, 0);
        chk("done_with_drop", done & drop, 0);
        if (rst_n && prev_rst) chk("pw_change_wo_load", pw_load | (pulse_width == prev_pw), 1);
        prev_pw   = pulse_width;
        prev_load = pw_load;
        prev_rst  = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_pw", pulse_width, 110000);
        chk("rst_busy", busy, 0);
        chk("rst_load", pw_load, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        l0 = load_cnt;
        frames(3);
        chk("idle_noload", load_cnt - l0, 0);
        chk("idle_busy", busy, 0);

        // Job 1: position 5, storage 103; coincident frame_start on the load is ignored.
        send(8'h05);
        chk("pos_noload", pw_load, 0);
        send(8'h67);
        chk("j1_load", pw_load, 1);
        chk("j1_pw", pulse_width, 50000);
        chk("j1_busy", busy, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("j1_single_load", pw_load, 0);
        l0 = load_cnt;
        d0 = done_cnt;
        frames(50);
        chk("j1_hold_noret", load_cnt - l0, 0);
        chk("j1_hold_busy", busy, 1);
        frames(1);
        chk("j1_ret_load", load_cnt - l0, 1);
        chk("j1_ret_pw", last_load_pw, 110000);
        frames(24);
        chk("j1_ret_wait", done_cnt - d0, 0);
        chk("j1_ret_busy", busy, 1);
        frames(1);
        chk("j1_done", done_cnt - d0, 1);
        chk("j1_idle", busy, 0);
        chk("j1_home_pw", pulse_width, 110000);

        // Job 2: position 1, storage 113.
        send(8'h01);
        send(8'h71);
        chk("j2_load", pw_load, 1);
        chk("j2_pw", pulse_width, 110000);
        tick();
        l0 = load_cnt;
        d0 = done_cnt;
        frames(10);
        chk("j2_hold_noret", load_cnt - l0, 0);
        frames(1);
        chk("j2_ret_load", load_cnt - l0, 1);
        frames(24);
        chk("j2_ret_wait", done_cnt - d0, 0);
        frames(1);
        chk("j2_done", done_cnt - d0, 1);
        chk("j2_idle", busy, 0);

        // Job 3: requests during HOLD.
        d0 = done_cnt;
        p0 = drop_cnt;
        send(8'h68);
        chk("j3_pw", pulse_width, 56000);
        tick();
        l0 = load_cnt;
        frames(3);
        send(8'h6C);
`ifdef SERVO_SEQ_QUEUE_EN
        chk("j3_108_drop", drop, 0);
`else
        chk("j3_108_drop", drop, 1);
`endif
        send(8'h69);
        chk("j3_105_drop", drop, 1);
        frames(8);
        chk("j3_ret_load", load_cnt - l0, 1);
        chk("j3_ret_pw", last_load_pw, 110000);
        frames(25);
        chk("j3_done", done_cnt - d0, 1);
`ifdef SERVO_SEQ_QUEUE_EN
        chk("j3_drops", drop_cnt - p0, 1);
        chk("j3_pend_pw", pulse_width, 80000);
        chk("j3_pend_busy", busy, 1);
        chk("j3_pend_load", load_cnt - l0, 2);
        frames(36);
        chk("j3_pend_done", done_cnt - d0, 2);
        chk("j3_pend_idle", busy, 0);
`else
        chk("j3_drops", drop_cnt - p0, 2);
        chk("j3_end_pw", pulse_width, 110000);
        chk("j3_end_busy", busy, 0);
        chk("j3_end_load", load_cnt - l0, 1);
`endif

        // Bytes outside both command ranges are ignored.
        l0 = load_cnt;
        p0 = drop_cnt;
        send(8'h00);
        send(8'h11);
        send(8'h66);
        send(8'h72);
        tick();
        chk("ign_load", load_cnt - l0, 0);
        chk("ign_drop", drop_cnt - p0, 0);
        chk("ign_busy", busy, 0);

        // Reset mid-HOLD, then a fresh job with position back at 1.
        send(8'h02);
        send(8'h6A);
        chk("r_pw", pulse_width, 68000);
        tick();
        frames(4);
        chk("r_hold_busy", busy, 1);
        l0 = load_cnt;
        rst_n = 1'b0;
        #1;
        chk("r_async_pw", pulse_width, 110000);
        chk("r_async_busy", busy, 0);
        chk("r_async_load", pw_load, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("r_noload", load_cnt - l0, 0);
        send(8'h68);
        chk("r_new_pw", pulse_width, 56000);
        tick();
        l0 = load_cnt;
        d0 = done_cnt;
        frames(10);
        chk("r_pos_reset", load_cnt - l0, 0);
        frames(1);
        chk("r_ret_load", load_cnt - l0, 1);
        frames(25);
        chk("r_done", done_cnt - d0, 1);
        chk("r_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/servo_job_sequencer.md
# servo_job_sequencer

- Sequences the servo PWM generator from decoded UART command bytes.
- Position bytes (1..16) set the dwell length. Storage bytes (103..113) start a job: move to the storage angle, hold, return home.
- Sits between the UART receiver and the PWM generator. Only this block writes the PWM generator's pulse width and load strobe.

## Interface
- PW_MIN, 50000: pulse width for storage 103, in clk cycles (1.0 ms at 50 MHz)
- PW_STEP, 6000: pulse-width increment per storage index
- PW_HOME, 110000: home pulse width (2.2 ms)
- DWELL_UNIT, 10: hold frames per position unit
- RETURN_FRAMES, 25: frames to wait after loading home before the job completes
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received command byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- frame_start  in  1  one-cycle pulse from the PWM generator at the start of each 20 ms frame
- pulse_width  out  26  pulse width presented to the PWM generator
- pw_load  out  1  one-cycle strobe; pulse_width is new this cycle
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- drop  out  1  one-cycle pulse when a storage command is rejected

## Operation
- Reset values:
  - Outputs: pulse_width=PW_HOME; pw_load, busy, done, drop = 0.
  - Internal: state=IDLE, position_r=1, pending empty.
- Byte decode, acted on only when rx_valid=1:
  - 1..16: position_r <= byte. Affects the next job only; a running job's dwell is already latched.
  - 103..113: job request with idx = byte-103 (0..10).
  - Every other value is ignored silently. No drop pulse.
- FSM states: IDLE, GO, HOLD, RET.
- IDLE + request:
  - Next cycle: state GO, pulse_width=PW_MIN+idx*PW_STEP, pw_load=1, busy=1.
  - Latch dwell_cnt=position_r*DWELL_UNIT.
- GO: wait for frame_start, then go to HOLD.
- HOLD:
  - Each frame_start decrements dwell_cnt.
  - When a frame_start brings dwell_cnt to 0: next cycle state RET, pulse_width=PW_HOME, pw_load=1, ret_cnt=RETURN_FRAMES.
- RET:
  - Each frame_start decrements ret_cnt.
  - When it reaches 0: done=1 for one cycle, busy=0, state IDLE.
  - If a job is pending, start it in the same cycle as done, with the IDLE+request timing. busy stays 1.
- Request while busy (any state other than IDLE, including the RET exit cycle): handled per Configuration.
- Arithmetic widths:
  - pulse_width: 26-bit unsigned, no saturation. Parameters must satisfy PW_MIN+10*PW_STEP < 2^26.
  - dwell_cnt: 16-bit. 16*DWELL_UNIT must be ≤ 65535.
- Reset mid-job: all outputs and state return to reset values at once. The job is abandoned and pw_load does not fire. The PWM generator shares rst_n and resets to home itself.

## Timing
- Request to pw_load: 1 cycle (byte registered, then outputs update).
- pw_load is never high two consecutive cycles. pulse_width changes only in a cycle where pw_load=1.
- frame_start coinciding with pw_load (GO entry) is not counted. The GO wait begins the following cycle.
- Job length: 1 + (GO wait) + position*DWELL_UNIT + RETURN_FRAMES frames, approximately.
- done and drop are one cycle wide and never asserted in the same cycle.

## Configuration
- SERVO_SEQ_QUEUE_EN defined:
  - One-deep pending register.
  - A request while busy is stored if pending is empty, and its idx is captured then. If pending is full, drop=1 for one cycle.
  - The position_r value in effect at pending job start sets its dwell.
- SERVO_SEQ_QUEUE_EN undefined:
  - No pending register.
  - Every request while busy gives drop=1 for one cycle and is discarded.

## Test plan
- Reset release, no stimulus: pulse_width=110000, busy=0, no pw_load for 3 frames.
- rx 0x05 then 0x67 (103):
  - pw_load with pulse_width=50000 one cycle after the 103 strobe.
  - After 1 + 50 frame_starts: pw_load with 110000.
  - After 25 more frame_starts: done pulse, busy=0.
- rx 0x71 (113) with position_r=1: pulse 110000, 10 hold frames, return home, done.
- rx 0x6C (108) during HOLD, then 0x69 (105):
  - QUEUE_EN: 108 pending; 105 gives drop; 108 starts at done with 80000.
  - No QUEUE_EN: drop on both.
- rx 0x00, 0x11, 0x66, 0x72 in IDLE: no pw_load, no drop, busy stays 0.
- Assert rst_n=0 mid-HOLD: pulse_width=110000, busy=0 immediately. A new 0x68 after release gives pulse_width=56000.
